// File: rtl/video_mixer.sv
// Purpose : mixes tile and sprite colour indices into a palette address and tracks HPOS/VPOS from the syncs.
// Latency : 3 clocks from input sample to PA/nBLANK (stage 1 capture, stage 2 select, stage 3 output).
// Backpressure: none; one pixel accepted and one result produced every clock, no stalls.
//
// Ports: CLK_6M pixel clock, nRST async active-low reset, nHSYNC/nVSYNC active-low syncs,
//        DOT/TPR tile index/priority, SDOT/SPRI sprite index/priority, nBANKWE/MD CPU bank write,
//        PA palette address {bank, source, index}, nBLANK active window, HPOS/VPOS counters.
// Option : define VIDEO_MIXER_LAYER_MASK_EN to add per-layer disable bits (MD[6] sprite, MD[7] tile).
module video_mixer #(
  parameter logic [8:0] H_ACTIVE_START = 9'd64,
  parameter logic [8:0] V_ACTIVE_START = 9'd16
) (
  input  logic       CLK_6M,
  input  logic       nRST,
  input  logic       nHSYNC,
  input  logic       nVSYNC,
  input  logic [7:0] DOT,
  input  logic [2:0] TPR,
  input  logic [7:0] SDOT,
  input  logic [2:0] SPRI,
  input  logic       nBANKWE,
  input  logic [7:0] MD,
  output logic [9:0] PA,
  output logic       nBLANK,
  output logic [8:0] HPOS,
  output logic [8:0] VPOS
);

  // Last active positions, computed one bit wider so a large start value cannot wrap.
  localparam logic [9:0] H_LAST = {1'b0, H_ACTIVE_START} + 10'd287;
  localparam logic [9:0] V_LAST = {1'b0, V_ACTIVE_START} + 10'd223;

  logic       hs_q, vs_q;
  logic       hs_fall, vs_fall;
  logic       bank_pending, bank_active;

  logic [7:0] s1_dot, s1_sdot;
  logic [2:0] s1_tpr, s1_spri;
  logic       s1_act;
  logic       s2_src, s2_act;
  logic [7:0] s2_idx;

  logic       active_now;
  logic       spr_opaque;
  logic [7:0] tile_idx;
  logic       sel_spr;

  // Sync history resets high so a sync held low through reset release is seen as a fall.
  assign hs_fall = hs_q & ~nHSYNC;
  assign vs_fall = vs_q & ~nVSYNC;

  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      HPOS <= 9'd0;
      VPOS <= 9'd0;
    end else begin
      hs_q <= nHSYNC;
      vs_q <= nVSYNC;
      if (hs_fall)
        HPOS <= 9'd0;
      else if (HPOS != 9'h1FF)
        HPOS <= HPOS + 9'd1;
      if (vs_fall)
        VPOS <= 9'd0;
      else if (hs_fall && (VPOS != 9'h1FF))
        VPOS <= VPOS + 9'd1;
    end
  end

  // bank_active samples the pre-write bank_pending, so a write coincident with a
  // line start only takes effect at the following line start.
  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      bank_pending <= 1'b0;
      bank_active  <= 1'b0;
    end else begin
      if (!nBANKWE)
        bank_pending <= MD[0];
      if (hs_fall)
        bank_active <= bank_pending;
    end
  end

`ifdef VIDEO_MIXER_LAYER_MASK_EN
  logic spr_dis, tile_dis;
  logic unused_md;
  assign unused_md = ^MD[5:1];

  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      spr_dis  <= 1'b0;
      tile_dis <= 1'b0;
    end else if (!nBANKWE) begin
      spr_dis  <= MD[6];
      tile_dis <= MD[7];
    end
  end

  assign spr_opaque = (s1_sdot[3:0] != 4'hF) && !spr_dis;
  assign tile_idx   = tile_dis ? 8'h00 : s1_dot;
`else
  logic unused_md;
  assign unused_md = ^MD[7:1];

  assign spr_opaque = (s1_sdot[3:0] != 4'hF);
  assign tile_idx   = s1_dot;
`endif

  assign active_now = (HPOS >= H_ACTIVE_START) && ({1'b0, HPOS} <= H_LAST) &&
                      (VPOS >= V_ACTIVE_START) && ({1'b0, VPOS} <= V_LAST);

  // Ties go to the sprite; a transparent sprite never wins.
  assign sel_spr = spr_opaque && (s1_spri >= s1_tpr);

  always_ff @(posedge CLK_6M or negedge nRST) begin
    if (!nRST) begin
      s1_dot  <= 8'h00;
      s1_tpr  <= 3'd0;
      s1_sdot <= 8'h00;
      s1_spri <= 3'd0;
      s1_act  <= 1'b0;
      s2_src  <= 1'b0;
      s2_idx  <= 8'h00;
      s2_act  <= 1'b0;
      PA      <= 10'h000;
      nBLANK  <= 1'b0;
    end else begin
      s1_dot  <= DOT;
      s1_tpr  <= TPR;
      s1_sdot <= SDOT;
      s1_spri <= SPRI;
      s1_act  <= active_now;
      s2_src  <= sel_spr;
      s2_idx  <= sel_spr ? s1_sdot : tile_idx;
      s2_act  <= s1_act;
      PA      <= s2_act ? {bank_active, s2_src, s2_idx} : 10'h000;
      nBLANK  <= s2_act;
    end
  end

endmodule
